// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   UART transmitter. Serialises one parallel word into a frame made of a start
//   bit, DATA_WIDTH data bits (LSB first), an optional parity bit and one stop
//   bit. Every bit is held for `prescale` clocks of the oversampled UART clock,
//   which is the same clock and prescale setting used by the receive path.
//
// Ports
//   clk        oversampled UART clock, all logic on the rising edge
//   reset      asynchronous, active-high reset
//   prescale   clocks per bit (0 and 1 both mean one clock); latched on accept
//   p_data     parallel word to transmit
//   data_valid p_data is valid; taken when ready is high
//   par_en     1 appends a parity bit; latched on accept
//   par_typ    0 even parity, 1 odd parity; latched on accept
//   ready      combinational; a word is accepted this cycle if data_valid
//   busy       registered; a frame is in progress
//   tx_out     registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            prescale,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  ready,
    output logic                  busy,
    output logic                  tx_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH - 1);

    state_t                state_reg,    state_next;
    logic [5:0]            edge_cnt_reg, edge_cnt_next;
    logic [3:0]            bit_cnt_reg,  bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg,    shift_next;
    logic [5:0]            prescale_reg, prescale_next;
    logic                  par_en_reg,   par_en_next;
    logic                  parity_reg,   parity_next;
    logic                  tx_out_reg,   tx_out_next;
    logic                  busy_reg,     busy_next;

    logic                  edge_last;
    logic                  accept;

    // Last clock of the current bit. A latched prescale of 0 or 1 gives a
    // single clock per bit, so the counter never leaves 0 in that case.
    assign edge_last = (prescale_reg <= 6'd1) || (edge_cnt_reg == (prescale_reg - 6'd1));

    // A new word can be taken while idle, or on the final stop clock so that
    // back-to-back frames run without an idle gap.
    assign ready  = (state_reg == IDLE) || ((state_reg == STOP) && edge_last);
    assign accept = data_valid & ready;

    assign busy   = busy_reg;
    assign tx_out = tx_out_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            prescale_reg <= '0;
            par_en_reg   <= 1'b0;
            parity_reg   <= 1'b0;
            tx_out_reg   <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            edge_cnt_reg <= edge_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            prescale_reg <= prescale_next;
            par_en_reg   <= par_en_next;
            parity_reg   <= parity_next;
            tx_out_reg   <= tx_out_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        edge_cnt_next = edge_last ? 6'd0 : (edge_cnt_reg + 6'd1);
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        prescale_next = prescale_reg;
        par_en_next   = par_en_reg;
        parity_next   = parity_reg;
        tx_out_next   = 1'b1;
        busy_next     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                edge_cnt_next = 6'd0;
            end
            START: begin
                if (edge_last) begin
                    state_next   = DATA;
                    bit_cnt_next = 4'd0;
                end
            end
            DATA: begin
                if (edge_last) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next = par_en_reg ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        // The bit on the line is always shift_reg[0].
                        shift_next   = shift_reg >> 1;
                    end
                end
            end
            PARITY: begin
                if (edge_last) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (edge_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next    = IDLE;
                edge_cnt_next = 6'd0;
            end
        endcase

        // Acceptance overrides the normal progression, including on the final
        // stop clock where it chains straight into the next start bit.
        if (accept) begin
            state_next    = START;
            edge_cnt_next = 6'd0;
            bit_cnt_next  = 4'd0;
            shift_next    = p_data;
            prescale_next = prescale;
            par_en_next   = par_en;
            parity_next   = (^p_data) ^ par_typ;
        end

        // The line level is decided from the state being entered so that it
        // appears on the flop output during that state's first clock.
        unique case (state_next)
            START:   tx_out_next = 1'b0;
            DATA:    tx_out_next = shift_next[0];
            PARITY:  tx_out_next = parity_next;
            default: tx_out_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter; counterpart of the receive-side edge/bit counter and sampler path.
- Serialises a parallel word into start bit, DATA_WIDTH data bits (LSB first), optional parity bit and one stop bit.
- Each bit is held for `prescale` clocks of the oversampled UART clock, so TX and RX share one clock and one prescale setting.
- Sits between the system-side TX FIFO/controller and the tx pin.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.

Ports:
- clk  input  1  oversampled UART clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- prescale  input  6  clocks per bit; latched at frame acceptance.
- p_data  input  DATA_WIDTH  parallel word to send.
- data_valid  input  1  p_data valid; accepted when ready=1.
- par_en  input  1  1 = append parity bit; latched at acceptance.
- par_typ  input  1  0 = even, 1 = odd; latched at acceptance.
- ready  output  1  combinational; block accepts a word this cycle.
- busy  output  1  registered; frame in progress.
- tx_out  output  1  registered serial line; idles high.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State = IDLE; counters = 0; shift register = 0.
  - tx_out=1, busy=0.
  - ready=1 once reset deasserts.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance: accept = data_valid & ready.
  - ready=1 in IDLE and in the last clock of STOP; 0 otherwise.
  - On accept, latch p_data, prescale, par_en and par_typ.
  - Parity bit computed at acceptance: even = XOR of the data bits; odd = inverted XOR.
  - data_valid with ready=0 is ignored; the word is not queued.
- Timing:
  - Accept in cycle T; tx_out=0 from T+1 (start bit).
  - busy=1 from T+1 until the end of the final stop clock.
- Bit timing:
  - Per-bit edge counter, 6 bit, counts 0..P-1, where P = latched prescale.
  - At P-1 the counter wraps to 0 and the FSM advances to the next bit.
  - P = 0 or 1 gives 1 clock per bit.
- Sequence:
  - START: tx_out=0 for P clocks.
  - DATA: bit counter, 4 bit, counts 0..DATA_WIDTH-1; tx_out = latched data[bit_cnt]; P clocks per bit.
  - After the last data bit: go to PARITY if par_en, else STOP.
  - PARITY: tx_out = parity bit for P clocks.
  - STOP: tx_out=1 for P clocks.
- End of STOP:
  - With accept on the last stop clock: go straight to START. No idle gap; busy stays 1.
  - Without accept: go to IDLE, busy=0, tx_out=1.
- Frame length = (2 + DATA_WIDTH + par_en) × P clocks.
- Changes to prescale, par_en, par_typ or p_data mid-frame have no effect on the current frame.
- Reset mid-frame:
  - Frame aborted; tx_out=1 and busy=0 immediately.
  - Latched word discarded; nothing resumes after reset.
- tx_out comes directly from a flop (glitch-free); it is never combinational from the FSM.

Test Plan:
- Even parity, P=8: reset, prescale=8, par_en=1, par_typ=0, p_data=0xA5 pulsed 1 clock.
  - tx_out = 0,1,0,1,0,0,1,0,1,0(parity),1, each held exactly 8 clocks.
  - busy high 88 clocks, then ready=1, tx_out=1.
- Odd parity, P=16: prescale=16, par_typ=1, p_data=0x07.
  - Data bits 1,1,1,0,0,0,0,0; parity bit 0.
  - Frame is 176 clocks.
- No parity, P=32: par_en=0, prescale=32, p_data=0xFF.
  - tx_out = 0 for 32 clocks, then 1 for 288 clocks.
  - busy high 320 clocks.
- Back-to-back frames: P=8, par_en=0, data_valid held high with 0x55 then 0x33, switching when ready was sampled high.
  - The 0x33 start bit begins the clock after the 0x55 stop bit's 8th clock.
  - busy never drops; ready=1 only on the last stop clock.
- Mid-frame changes and ignored requests: during DATA of 0xA5, change prescale to 16 and pulse data_valid with 0x3C.
  - The frame completes with 8-clock bits.
  - 0x3C is never transmitted.
- Reset mid-frame: assert reset during data bit 3.
  - tx_out=1 and busy=0 in the same cycle.
  - After release, a new 0x81 frame at P=8 is transmitted cleanly.
